// File: rtl/watch_pkg.sv
// Shared watch definitions: alarm FSM state encoding and time-field limits.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_ARMED,
    ST_RINGING,
    ST_SNOOZE
  } alarm_state_e;

  localparam logic [7:0] SEC_MAX  = 8'd59;
  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam logic [7:0] HOUR_MAX = 8'd23;

endpackage

// File: rtl/alarm_match.sv
// Alarm time comparator with registered match and rising-edge trigger.
// Also usable for an hourly chime by tying the minute compare inputs.
module alarm_match
  import watch_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cur_second,
  input  logic [7:0] cur_minute,
  input  logic [7:0] cur_hour,
  input  logic [7:0] alm_minute,
  input  logic [7:0] alm_hour,
  output logic       match,
  output logic       trigger
);

  logic match_d;

  assign match   = (cur_hour == alm_hour) && (cur_minute == alm_minute) && (cur_second == 8'd0);
  // One trigger per alarm minute no matter how long the match holds.
  assign trigger = match && !match_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      match_d <= 1'b0;
    end else begin
      match_d <= match;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: arm/disarm, bounded ring with beep pattern, stop and snooze.
// Optional snooze support is enabled by defining ALARM_SNOOZE_EN.
module alarm_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_SECONDS = 300
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_sec,
  input  logic       alarm_toggle,
  input  logic       stop,
  input  logic       snooze,
  input  logic [7:0] cur_second,
  input  logic [7:0] cur_minute,
  input  logic [7:0] cur_hour,
  input  logic [7:0] alm_minute,
  input  logic [7:0] alm_hour,
  output logic       alarm_on,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer
);

  localparam int unsigned RW = $clog2(RING_SECONDS + 1);

  alarm_state_e  state;
  logic [RW-1:0] ring_cnt;
  logic          alarm_on_q;
  logic          ringing_q;
  logic          buzzer_q;
  logic          match;
  logic          trigger;

  alarm_match u_match (
    .clock      (clock),
    .reset      (reset),
    .cur_second (cur_second),
    .cur_minute (cur_minute),
    .cur_hour   (cur_hour),
    .alm_minute (alm_minute),
    .alm_hour   (alm_hour),
    .match      (match),
    .trigger    (trigger)
  );

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SW = $clog2(SNOOZE_SECONDS + 1);
  logic [SW-1:0] snooze_cnt;
  logic          snoozing_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_OFF;
      ring_cnt   <= '0;
      alarm_on_q <= 1'b0;
      ringing_q  <= 1'b0;
      buzzer_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt <= '0;
      snoozing_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_OFF: begin
          if (alarm_toggle) begin
            state      <= ST_ARMED;
            alarm_on_q <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (alarm_toggle) begin
            state      <= ST_OFF;
            alarm_on_q <= 1'b0;
          end else if (trigger) begin
            state     <= ST_RINGING;
            ring_cnt  <= '0;
            ringing_q <= 1'b1;
            buzzer_q  <= 1'b1;
          end
        end
        ST_RINGING: begin
          if (alarm_toggle) begin
            state      <= ST_OFF;
            alarm_on_q <= 1'b0;
            ringing_q  <= 1'b0;
            buzzer_q   <= 1'b0;
          end else if (stop) begin
            state     <= ST_ARMED;
            ringing_q <= 1'b0;
            buzzer_q  <= 1'b0;
          end else if (snooze) begin
            ringing_q <= 1'b0;
            buzzer_q  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            state      <= ST_SNOOZE;
            snooze_cnt <= '0;
            snoozing_q <= 1'b1;
`else
            state      <= ST_ARMED;
`endif
          end else if (tick_sec) begin
            if (ring_cnt == RW'(RING_SECONDS - 1)) begin
              state     <= ST_ARMED;
              ringing_q <= 1'b0;
              buzzer_q  <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 1'b1;
              buzzer_q <= ~buzzer_q;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (alarm_toggle) begin
            state      <= ST_OFF;
            alarm_on_q <= 1'b0;
            snoozing_q <= 1'b0;
          end else if (stop) begin
            state      <= ST_ARMED;
            snoozing_q <= 1'b0;
          end else if (tick_sec) begin
            if (snooze_cnt == SW'(SNOOZE_SECONDS - 1)) begin
              state      <= ST_RINGING;
              ring_cnt   <= '0;
              ringing_q  <= 1'b1;
              buzzer_q   <= 1'b1;
              snoozing_q <= 1'b0;
            end else begin
              snooze_cnt <= snooze_cnt + 1'b1;
            end
          end
        end
`endif
        default: begin
          state      <= ST_OFF;
          alarm_on_q <= 1'b0;
          ringing_q  <= 1'b0;
          buzzer_q   <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_on = alarm_on_q;
  assign ringing  = ringing_q;
  assign buzzer   = buzzer_q;
`ifdef ALARM_SNOOZE_EN
  assign snoozing = snoozing_q;
`else
  assign snoozing = 1'b0;
`endif

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm sequencer for the digital watch.
- Compares the running time against the stored alarm minute/hour and arms/disarms the alarm.
- Drives the buzzer for a bounded ring period and handles stop and snooze requests.
- Sits between the time-keeping counters, the alarm-setting register and the buzzer/LED outputs.

Parameters:
- RING_SECONDS, 60, number of tick_sec pulses a ring lasts before auto-stop (1..255).
- SNOOZE_SECONDS, 300, number of tick_sec pulses spent in snooze before re-ringing (1..1023).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tick_sec  input  1  one-cycle pulse, once per second, coincident with the time-counter update.
- alarm_toggle  input  1  one-cycle pulse (debounced button); toggles alarm enable.
- stop  input  1  one-cycle pulse; silences ring or cancels snooze.
- snooze  input  1  one-cycle pulse; defers the ring.
- cur_second  input  8  current second, binary 0..59.
- cur_minute  input  8  current minute, binary 0..59.
- cur_hour  input  8  current hour, binary 0..23.
- alm_minute  input  8  alarm minute, binary 0..59.
- alm_hour  input  8  alarm hour, binary 0..23.
- alarm_on  output  1  alarm enabled (state != OFF).
- ringing  output  1  state == RINGING.
- snoozing  output  1  state == SNOOZE.
- buzzer  output  1  beep pattern: toggles on each tick_sec while RINGING, 0 otherwise.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- On reset:
  - state = OFF.
  - All outputs 0.
  - ring_cnt, snooze_cnt and match_d cleared.
- match = (cur_hour==alm_hour) & (cur_minute==alm_minute) & (cur_second==0), a full 8-bit compare. match_d is match registered every cycle.
- trigger = match & ~match_d (rising edge). Exactly one trigger per alarm minute, regardless of how long match holds.
- States and transitions are listed in priority order; the first applicable rule wins within a cycle.
  - OFF:
    - alarm_toggle -> ARMED.
    - All other inputs ignored.
  - ARMED:
    - alarm_toggle -> OFF.
    - trigger -> RINGING; ring_cnt=0; buzzer=1.
  - RINGING:
    - alarm_toggle -> OFF.
    - stop -> ARMED.
    - snooze -> SNOOZE; snooze_cnt=0.
    - tick_sec with ring_cnt==RING_SECONDS-1 -> ARMED (auto-stop).
    - Otherwise tick_sec: ring_cnt+1 and buzzer toggles.
  - SNOOZE:
    - alarm_toggle -> OFF.
    - stop -> ARMED.
    - tick_sec with snooze_cnt==SNOOZE_SECONDS-1 -> RINGING; ring_cnt=0; buzzer=1.
    - Otherwise tick_sec: snooze_cnt+1.
- trigger is ignored in RINGING and SNOOZE; the alarm does not restart mid-ring.
- All outputs are registered: they change on the clock edge following the causing input, so latency is 1 cycle.
- buzzer is forced 0 in every state other than RINGING.
- Alarm time changes during RINGING/SNOOZE have no effect on the current cycle; a new match is only acted on in ARMED.
- Reset asserted mid-ring or mid-snooze returns the block to OFF. The alarm must be re-armed by alarm_toggle.
- Counter widths are $clog2(param+1). Counters saturate, never wrap; reaching the terminal value always forces a transition.

Optional Feature:
- ALARM_SNOOZE_EN
  - Defined: SNOOZE state, snooze_cnt and the snoozing output behave as above.
  - Undefined: no SNOOZE state or counter; snooze behaves identically to stop (RINGING -> ARMED); snoozing is tied to 0; SNOOZE_SECONDS is unused.

Decomposition:
- Shared package watch_pkg holds:
  - the state enum (ST_OFF, ST_ARMED, ST_RINGING, ST_SNOOZE);
  - time-limit constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
- One sub-module is natural: alarm_match. It is the combinational comparator plus the match_d register and edge detect, producing trigger, and is reusable for the hourly chime.
- The FSM and counters stay in alarm_ctrl.

Test Plan:
- Reset, then alarm_toggle; alm=07:30; drive time 07:29:59 -> 07:30:00 with tick_sec -> alarm_on=1, ringing=1 one cycle later, buzzer=1.
- Ringing, apply 60 tick_sec (RING_SECONDS=60) -> ringing drops after the 60th tick, state ARMED, buzzer=0, and no re-trigger while time stays 07:30:xx.
- Ringing, pulse snooze -> snoozing=1, buzzer=0; after 300 ticks -> ringing=1 again. With ALARM_SNOOZE_EN undefined -> snooze returns to ARMED.
- Ringing, alarm_toggle and stop in the same cycle -> OFF (toggle priority), alarm_on=0; a later match produces no ring.
- Armed, alm=12:00, time passes 12:00:00 while OFF, then alarm enabled at 12:00:05 -> no ring (edge already passed).
- Reset asserted during SNOOZE -> all outputs 0, state OFF; the next alarm time match produces no ring.
